// File: rtl/i2c_eeprom_slave.sv
// I2C serial EEPROM slave with a paged write buffer and a timed internal write cycle.
// Every bus decision is taken on the clk-synchronised copies of SCL and SDA.
`timescale 1ns/1ps
module i2c_eeprom_slave #(
  parameter int         ADDR_W    = 11,
  parameter logic [3:0] DEV_ID    = 4'b1010,
  parameter int         PAGE_SIZE = 16,
  parameter int         WR_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BI_W  = (PAGE_SIZE > 1) ? $clog2(PAGE_SIZE) : 1;
  localparam int CW    = $clog2(WR_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PMASK    = ADDR_W'(PAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(8'hFF);
  localparam logic [CW-1:0]     WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0]     PAGE_LIM = CW'(PAGE_SIZE);
  localparam logic [8:0]        PAGE_CNT = 9'(PAGE_SIZE);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t state_r, state_s;
  logic scl_meta_r, scl_sync_r, scl_hist_r;
  logic sda_meta_r, sda_sync_r, sda_hist_r;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] shift_r;
  logic rw_r, rw_s;
  logic sda_oe_r, oe_s;
  logic [ADDR_W-1:0] ptr_r, ptr_s;
  logic [8:0] cnt_r, cnt_s;
  logic [PAGE_SIZE-1:0] valid_r;
  logic busy_r;
  logic [CW-1:0] wr_cnt_r;
  logic buf_we_s, buf_clr_s, start_wr_s, commit_s;
  logic [7:0] mem_r [DEPTH];
  logic [7:0] page_r [PAGE_SIZE];
  logic [7:0] rd_byte_s;
  logic [BI_W-1:0] buf_idx_s, wr_idx_s;
  logic [ADDR_W-1:0] commit_addr_s;

  assign sda_oe = sda_oe_r;
  assign busy   = busy_r;

  // Synchronisers reset to the idle-high bus level so no spurious edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_meta_r, scl_sync_r, scl_hist_r} <= 3'b111;
      {sda_meta_r, sda_sync_r, sda_hist_r} <= 3'b111;
    end else begin
      {scl_meta_r, scl_sync_r, scl_hist_r} <= {scl_i, scl_meta_r, scl_sync_r};
      {sda_meta_r, sda_sync_r, sda_hist_r} <= {sda_i, sda_meta_r, sda_sync_r};
    end
  end

  assign scl_rise_s = scl_sync_r & ~scl_hist_r;
  assign scl_fall_s = ~scl_sync_r & scl_hist_r;
  assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;

  assign rd_byte_s     = mem_r[ptr_r];
  assign buf_idx_s     = BI_W'(ptr_r & PMASK);
  assign wr_idx_s      = BI_W'(wr_cnt_r);
  assign commit_s      = busy_r && (wr_cnt_r < PAGE_LIM) && valid_r[wr_idx_s];
  assign commit_addr_s = (ptr_r & ~PMASK) | (ADDR_W'(wr_idx_s) & PMASK);

  // Next-state and next-output logic; bus outputs only move on an SCL falling edge.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    ptr_s      = ptr_r;
    oe_s       = sda_oe_r;
    rw_s       = rw_r;
    cnt_s      = cnt_r;
    buf_we_s   = 1'b0;
    buf_clr_s  = 1'b0;
    start_wr_s = 1'b0;
    if (stop_s) begin
      state_s    = IDLE;
      bit_cnt_s  = 4'd0;
      oe_s       = 1'b0;
      start_wr_s = (state_r == WDATA) && (cnt_r != 9'd0);
    end else if (start_s) begin
      state_s   = DEV;
      bit_cnt_s = 4'd0;
      oe_s      = 1'b0;
    end else if (scl_rise_s) begin
      case (state_r)
        DEV, ADDR, WDATA, RDATA: bit_cnt_s = bit_cnt_r + 4'd1;
        default:                 bit_cnt_s = bit_cnt_r;
      endcase
    end else if (scl_fall_s) begin
      case (state_r)
        DEV: begin
          if (bit_cnt_r == 4'd8) begin
            bit_cnt_s = 4'd0;
            if ((shift_r[7:4] == DEV_ID) && !busy_r) begin
              state_s = DEV_ACK;
              oe_s    = 1'b1;
              rw_s    = shift_r[0];
              // Block bits of a write control byte select the upper address bits.
              ptr_s   = shift_r[0] ? ptr_r : (ADDR_W'({shift_r[3:1], 8'h00}) | (ptr_r & LOW_MASK));
            end else begin
              state_s = IDLE;
              oe_s    = 1'b0;
            end
          end else begin
            state_s = DEV;
          end
        end
        DEV_ACK: begin
          bit_cnt_s = 4'd0;
          if (rw_r) begin
            state_s = RDATA;
            oe_s    = ~rd_byte_s[7];
          end else begin
            state_s   = ADDR;
            oe_s      = 1'b0;
            buf_clr_s = 1'b1;
            cnt_s     = 9'd0;
          end
        end
        ADDR: begin
          if (bit_cnt_r == 4'd8) begin
            state_s   = ADDR_ACK;
            bit_cnt_s = 4'd0;
            oe_s      = 1'b1;
            ptr_s     = (ptr_r & ~LOW_MASK) | ADDR_W'(shift_r);
          end else begin
            state_s = ADDR;
          end
        end
        ADDR_ACK, WDATA_ACK: begin
          state_s   = WDATA;
          bit_cnt_s = 4'd0;
          oe_s      = 1'b0;
        end
        WDATA: begin
          if (bit_cnt_r == 4'd8) begin
            state_s   = WDATA_ACK;
            bit_cnt_s = 4'd0;
            oe_s      = 1'b1;
            buf_we_s  = 1'b1;
            cnt_s     = (cnt_r == PAGE_CNT) ? cnt_r : cnt_r + 9'd1;
            ptr_s     = (ptr_r & ~PMASK) | ((ptr_r + ADDR_W'(1)) & PMASK);
          end else begin
            state_s = WDATA;
          end
        end
        RDATA: begin
          if (bit_cnt_r == 4'd8) begin
            state_s   = RACK;
            bit_cnt_s = 4'd0;
            oe_s      = 1'b0;
            ptr_s     = ptr_r + ADDR_W'(1);
          end else begin
            oe_s = ~rd_byte_s[3'd7 - bit_cnt_r[2:0]];
          end
        end
        RACK: begin
          bit_cnt_s = 4'd0;
          if (!shift_r[0]) begin
            state_s = RDATA;
            oe_s    = ~rd_byte_s[7];
          end else begin
            state_s = IDLE;
            oe_s    = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          oe_s    = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Protocol state, pointer and page-buffer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      rw_r      <= 1'b0;
      sda_oe_r  <= 1'b0;
      ptr_r     <= '0;
      cnt_r     <= 9'd0;
      valid_r   <= '0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      rw_r      <= rw_s;
      sda_oe_r  <= oe_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      if (scl_rise_s) shift_r <= {shift_r[6:0], sda_sync_r};
      if (buf_clr_s) valid_r <= '0;
      else if (buf_we_s) valid_r[buf_idx_s] <= 1'b1;
    end
  end

  // Write-cycle timer: busy stays high for exactly WR_CYCLES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      wr_cnt_r <= '0;
    end else if (start_wr_s) begin
      busy_r   <= 1'b1;
      wr_cnt_r <= '0;
    end else if (busy_r) begin
      busy_r   <= (wr_cnt_r != WR_LAST);
      wr_cnt_r <= (wr_cnt_r == WR_LAST) ? '0 : wr_cnt_r + CW'(1);
    end
  end

  // Page buffer capture; one buffered byte is committed per clock early in the write cycle.
  always_ff @(posedge clk) begin
    if (buf_we_s) page_r[buf_idx_s] <= shift_r;
    if (commit_s) mem_r[commit_addr_s] <= page_r[wr_idx_s];
  end
endmodule
